// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI channel-message parser.
package midi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } midi_state_e;

  // Status high nibbles of channel voice messages
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] BEND     = 4'hE;

  localparam logic [13:0] BEND_CENTER = 14'h2000;

endpackage

// File: rtl/midi_parser.sv
// MIDI byte-stream parser with running status; turns note, CC and pitch-bend
// messages on the receive channel into registered one-cycle event pulses.
module midi_parser
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic        i_clk_aud,
  input  logic        i_aud_rst,
  // i_ready is a one-cycle strobe: i_data_byte is consumed only in a cycle
  // where i_ready=1; there is no back-pressure toward the UART receiver.
  input  logic        i_ready,
  input  logic [7:0]  i_data_byte,
  output logic        o_note_on,
  output logic        o_note_off,
  output logic [6:0]  o_note,
  output logic [6:0]  o_velocity,
  output logic        o_cc_valid,
  output logic [6:0]  o_cc_num,
  output logic [6:0]  o_cc_value,
  output logic        o_bend_valid,
  output logic [13:0] o_bend,
  output midi_state_e o_state
);

  midi_state_e state_q, state_d;
  logic [7:0]  status_q, status_d;
  logic [6:0]  d1_q, d1_d;
  logic        note_on_d, note_off_d, cc_valid_d, bend_valid_d;
  logic [6:0]  note_d, velocity_d, cc_num_d, cc_value_d;
  logic [13:0] bend_d;
  logic [3:0]  kind;
  logic [6:0]  d2;
  logic        chan_ok;

  assign kind    = status_q[7:4];
  assign d2      = i_data_byte[6:0];
  assign chan_ok = OMNI || (status_q[3:0] == CHANNEL[3:0]);
  assign o_state = state_q;

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    d1_d         = d1_q;
    note_on_d    = 1'b0;
    note_off_d   = 1'b0;
    cc_valid_d   = 1'b0;
    bend_valid_d = 1'b0;
    note_d       = o_note;
    velocity_d   = o_velocity;
    cc_num_d     = o_cc_num;
    cc_value_d   = o_cc_value;
    bend_d       = o_bend;

    // Real-time bytes (0xF8-0xFF) fall through untouched
    if (i_ready && (i_data_byte[7:3] != 5'b11111)) begin
      if (i_data_byte[7]) begin
        if (i_data_byte[7:4] != 4'hF) begin
          status_d = i_data_byte;
          state_d  = WAIT_D1;
        end else begin
          status_d = 8'h00;
          state_d  = (i_data_byte == 8'hF0) ? SYSEX : IDLE;
        end
      end else begin
        case (state_q)
          WAIT_D1: begin
            d1_d    = i_data_byte[6:0];
            state_d = ((kind == PROG) || (kind == CHAN_AT)) ? WAIT_D1 : WAIT_D2;
          end
          WAIT_D2: begin
            state_d = WAIT_D1;
            if (chan_ok) begin
              case (kind)
                NOTE_ON: begin
                  // Velocity zero is the running-status form of note-off
                  note_on_d  = (d2 != 7'd0);
                  note_off_d = (d2 == 7'd0);
                  note_d     = d1_q;
                  velocity_d = d2;
                end
                NOTE_OFF: begin
                  note_off_d = 1'b1;
                  note_d     = d1_q;
                  velocity_d = d2;
                end
                CC: begin
                  cc_valid_d = 1'b1;
                  cc_num_d   = d1_q;
                  cc_value_d = d2;
                end
                BEND: begin
                  bend_valid_d = 1'b1;
                  bend_d       = {d2, d1_q};
                end
                default: begin
                end
              endcase
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_clk_aud) begin
    if (i_aud_rst) begin
      state_q      <= IDLE;
      status_q     <= 8'h00;
      d1_q         <= 7'd0;
      o_note_on    <= 1'b0;
      o_note_off   <= 1'b0;
      o_cc_valid   <= 1'b0;
      o_bend_valid <= 1'b0;
      o_note       <= 7'd0;
      o_velocity   <= 7'd0;
      o_cc_num     <= 7'd0;
      o_cc_value   <= 7'd0;
      o_bend       <= BEND_CENTER;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      d1_q         <= d1_d;
      o_note_on    <= note_on_d;
      o_note_off   <= note_off_d;
      o_cc_valid   <= cc_valid_d;
      o_bend_valid <= bend_valid_d;
      o_note       <= note_d;
      o_velocity   <= velocity_d;
      o_cc_num     <= cc_num_d;
      o_cc_value   <= cc_value_d;
      o_bend       <= bend_d;
    end
  end

endmodule

// File: tb/tb_midi_parser.sv
// Directed bench for midi_parser: a channel-0 instance and an OMNI instance
// share one byte stream; per-cycle expectations come from a vector table.
module tb_midi_parser;
  import midi_pkg::*;

  localparam int EV_NONE = 0;
  localparam int EV_ON   = 1;
  localparam int EV_OFF  = 2;
  localparam int EV_CC   = 3;
  localparam int EV_BEND = 4;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [7:0] data;
    logic [1:0] st;
    int         ev;
    logic [6:0] a;
    logic [6:0] b;
    logic       on_b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [7:0]  data;

  logic        on_a, off_a, cc_a, bv_a;
  logic [6:0]  note_a, vel_a, ccn_a, ccv_a;
  logic [13:0] bend_a;
  midi_state_e st_a;

  logic        on_b, off_b, cc_b, bv_b;
  logic [6:0]  note_b, vel_b, ccn_b, ccv_b;
  logic [13:0] bend_b;
  midi_state_e st_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Held-value model of the data outputs
  logic [6:0]  m_note, m_vel, m_ccn, m_ccv;
  logic [13:0] m_bend;

  vec_t vecs[$];

  always #5 clk = ~clk;

  midi_parser #(.CHANNEL(0), .OMNI(1'b0)) dut_a (
    .i_clk_aud(clk), .i_aud_rst(rst), .i_ready(rdy), .i_data_byte(data),
    .o_note_on(on_a), .o_note_off(off_a), .o_note(note_a), .o_velocity(vel_a),
    .o_cc_valid(cc_a), .o_cc_num(ccn_a), .o_cc_value(ccv_a),
    .o_bend_valid(bv_a), .o_bend(bend_a), .o_state(st_a)
  );

  midi_parser #(.CHANNEL(0), .OMNI(1'b1)) dut_b (
    .i_clk_aud(clk), .i_aud_rst(rst), .i_ready(rdy), .i_data_byte(data),
    .o_note_on(on_b), .o_note_off(off_b), .o_note(note_b), .o_velocity(vel_b),
    .o_cc_valid(cc_b), .o_cc_num(ccn_b), .o_cc_value(ccv_b),
    .o_bend_valid(bv_b), .o_bend(bend_b), .o_state(st_b)
  );

  function automatic vec_t v(input logic r, input logic rd, input logic [7:0] d,
                             input logic [1:0] s, input int e,
                             input logic [6:0] a, input logic [6:0] b,
                             input logic ob);
    vec_t t;
    t.rst = r; t.rdy = rd; t.data = d; t.st = s; t.ev = e;
    t.a = a; t.b = b; t.on_b = ob;
    return t;
  endfunction

  task automatic check(input int idx, input vec_t t);
    logic [46:0] exp_v, act_v;
    logic        e_on, e_off, e_cc, e_bv;
    e_on = 1'b0; e_off = 1'b0; e_cc = 1'b0; e_bv = 1'b0;
    if (t.rst) begin
      m_note = 7'd0; m_vel = 7'd0; m_ccn = 7'd0; m_ccv = 7'd0; m_bend = 14'h2000;
    end else begin
      case (t.ev)
        EV_ON:   begin e_on  = 1'b1; m_note = t.a; m_vel = t.b; end
        EV_OFF:  begin e_off = 1'b1; m_note = t.a; m_vel = t.b; end
        EV_CC:   begin e_cc  = 1'b1; m_ccn  = t.a; m_ccv = t.b; end
        EV_BEND: begin e_bv  = 1'b1; m_bend = {t.b, t.a}; end
        default: begin end
      endcase
    end
    exp_v = {e_on, e_off, m_note, m_vel, e_cc, m_ccn, m_ccv, e_bv, m_bend, t.on_b};
    act_v = {on_a, off_a, note_a, vel_a, cc_a, ccn_a, ccv_a, bv_a, bend_a, on_b};
    n_checks++;
    if (act_v === exp_v) n_pass++;
    else $display("FAIL outputs vec%0d byte=%h: got %h expected %h", idx, t.data, act_v, exp_v);
    n_checks++;
    if (2'(st_a) === t.st) n_pass++;
    else $display("FAIL state vec%0d byte=%h: got %0d expected %0d", idx, t.data, 2'(st_a), t.st);
  endtask

  task automatic apply(input int idx, input vec_t t);
    @(negedge clk);
    rst = t.rst; rdy = t.rdy; data = t.data;
    @(posedge clk);
    #1;
    check(idx, t);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b0; data = 8'h00;
    m_note = 7'd0; m_vel = 7'd0; m_ccn = 7'd0; m_ccv = 7'd0; m_bend = 14'h2000;

    // reset, and a strobe during reset is ignored
    vecs.push_back(v(1, 0, 8'h00, 0, EV_NONE, 0, 0, 0));
    vecs.push_back(v(1, 1, 8'h90, 0, EV_NONE, 0, 0, 0));
    // note-on, then running-status note-on with velocity 0
    vecs.push_back(v(0, 1, 8'h90, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h3C, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h64, 1, EV_ON, 7'h3C, 7'h64, 1));
    vecs.push_back(v(0, 0, 8'h55, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h3E, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h00, 1, EV_OFF, 7'h3E, 7'h00, 0));
    // other channel: filtered on dut_a, accepted by the OMNI instance
    vecs.push_back(v(0, 1, 8'h91, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h40, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h7F, 1, EV_NONE, 0, 0, 1));
    // CC with interleaved real-time bytes
    vecs.push_back(v(0, 1, 8'hB0, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'hF8, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h07, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'hFE, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h64, 1, EV_CC, 7'h07, 7'h64, 0));
    // pitch bend centre and maximum
    vecs.push_back(v(0, 1, 8'hE0, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h00, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h40, 1, EV_BEND, 7'h00, 7'h40, 0));
    vecs.push_back(v(0, 1, 8'h7F, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h7F, 1, EV_BEND, 7'h7F, 7'h7F, 0));
    // sysex swallows data, F7 leaves no running status
    vecs.push_back(v(0, 1, 8'hF0, 3, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h3C, 3, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h64, 3, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'hF7, 0, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h3C, 0, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h64, 0, EV_NONE, 0, 0, 0));
    // explicit note-off keeps its velocity
    vecs.push_back(v(0, 1, 8'h80, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h41, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h22, 1, EV_OFF, 7'h41, 7'h22, 0));
    // program change: one data byte, stays in WAIT_D1
    vecs.push_back(v(0, 1, 8'hC0, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h05, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h06, 1, EV_NONE, 0, 0, 0));
    // status in WAIT_D2 aborts; poly aftertouch is silent
    vecs.push_back(v(0, 1, 8'h90, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h30, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'hA0, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h10, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h20, 1, EV_NONE, 0, 0, 0));
    // reset mid-message discards the partial note
    vecs.push_back(v(0, 1, 8'h90, 1, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h3C, 2, EV_NONE, 0, 0, 0));
    vecs.push_back(v(1, 0, 8'h00, 0, EV_NONE, 0, 0, 0));
    vecs.push_back(v(0, 1, 8'h64, 0, EV_NONE, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Hand sequence: a status byte present without a strobe must not be taken
    apply(100, v(0, 1, 8'hB0, 1, EV_NONE, 0, 0, 0));
    apply(101, v(0, 0, 8'h90, 1, EV_NONE, 0, 0, 0));
    apply(102, v(0, 1, 8'h01, 2, EV_NONE, 0, 0, 0));
    apply(103, v(0, 1, 8'h02, 1, EV_CC, 7'h01, 7'h02, 0));
    apply(104, v(0, 0, 8'h02, 1, EV_NONE, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/midi_parser.md
MIDI_PARSER -- requirements
Module: midi_parser

Interface
REQ-001 The block SHALL have parameter CHANNEL, default 0, meaning the MIDI receive channel 0-15 that is matched against the status low nibble.
REQ-002 The block SHALL have parameter OMNI, default 0, meaning that when set to 1 messages on all channels are accepted.
REQ-003 The block SHALL have port i_clk_aud, input, 1 bit: the single audio clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_aud_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_ready, input, 1 bit: one-cycle strobe marking i_data_byte valid, from the MIDI UART receiver.
REQ-006 The block SHALL have port i_data_byte, input, 8 bits: the received MIDI byte.
REQ-007 The block SHALL have port o_note_on, output, 1 bit: one-cycle note-on event pulse.
REQ-008 The block SHALL have port o_note_off, output, 1 bit: one-cycle note-off event pulse.
REQ-009 The block SHALL have port o_note, output, 7 bits: note number of the last note event.
REQ-010 The block SHALL have port o_velocity, output, 7 bits: velocity of the last note event.
REQ-011 The block SHALL have port o_cc_valid, output, 1 bit: one-cycle control-change pulse.
REQ-012 The block SHALL have ports o_cc_num and o_cc_value, outputs, 7 bits each: controller number and value of the last CC.
REQ-013 The block SHALL have port o_bend_valid, output, 1 bit: one-cycle pitch-bend pulse.
REQ-014 The block SHALL have port o_bend, output, 14 bits: unsigned pitch bend {msb,lsb}, centre 0x2000.

Function
REQ-015 The block SHALL accept a byte only in a cycle with i_ready=1; all other cycles leave state unchanged.
REQ-016 The block SHALL use states IDLE (no running status), WAIT_D1, WAIT_D2 and SYSEX.
REQ-017 The block SHALL ignore bytes 0xF8-0xFF (real-time) in any state, with no change to state, running status or outputs.
REQ-018 On 0x80-0xEF in any state, the block SHALL store the byte as running status and go to WAIT_D1, discarding any partial message.
REQ-019 On 0xF0, the block SHALL clear running status and enter SYSEX; on 0xF1-0xF7, it SHALL clear running status and enter IDLE.
REQ-020 The block SHALL discard data bytes (bit7=0) in IDLE and SYSEX.
REQ-021 In WAIT_D1, a data byte SHALL be latched as d1; for status 0xC_/0xD_ the message is then complete with no output and the state stays WAIT_D1; for other statuses the state goes to WAIT_D2.
REQ-022 In WAIT_D2, a data byte SHALL complete the message as d2, after which the state returns to WAIT_D1 (running status).
REQ-023 On completion, the block SHALL emit events only if OMNI=1 or status[3:0]==CHANNEL.
REQ-024 Event outputs SHALL be registered, with the pulse high exactly in the cycle after the i_ready of the completing byte, and at most one *_valid/note pulse per cycle.
REQ-025 The 0x9_ status with d2 != 0 SHALL produce o_note_on, o_note=d1, o_velocity=d2.
REQ-026 The 0x9_ status with d2 == 0 SHALL produce o_note_off, o_note=d1, o_velocity=0.
REQ-027 The 0x8_ status SHALL produce o_note_off, o_note=d1, o_velocity=d2.
REQ-028 The 0xB_ status SHALL produce o_cc_valid, o_cc_num=d1, o_cc_value=d2.
REQ-029 The 0xE_ status SHALL produce o_bend_valid, o_bend={d2,d1}.
REQ-030 The 0xA_ status (poly aftertouch) SHALL be parsed and produce no output.
REQ-031 Data outputs SHALL hold their last value until the next event of the same type.
REQ-032 A status byte arriving in WAIT_D2 SHALL abort the partial message with no output.

Reset
REQ-033 While i_aud_rst=1, the state SHALL be IDLE, running status and d1 cleared, all pulses 0, o_note/o_velocity/o_cc_num/o_cc_value 0, and o_bend 0x2000.
REQ-034 i_ready during reset SHALL be ignored, and a reset mid-message SHALL discard the partial message with no event emitted after reset release.

Structure
REQ-035 The package midi_pkg SHALL hold the parser state enum, status-nibble constants (NOTE_OFF=0x8, NOTE_ON=0x9, POLY_AT=0xA, CC=0xB, PROG=0xC, CHAN_AT=0xD, BEND=0xE) and BEND_CENTER=0x2000.
REQ-036 The block SHALL be a single module with no sub-module, placed directly downstream of the MIDI UART receiver.

Verification
REQ-037 Bytes 0x90,0x3C,0x64 (CHANNEL=0) SHALL produce o_note_on one cycle after the third strobe, o_note=0x3C, o_velocity=0x64.
REQ-038 Bytes 0x90,0x3C,0x64 followed by 0x3E,0x00 (running status) SHALL produce note_on 0x3C, then note_off o_note=0x3E, o_velocity=0.
REQ-039 Bytes 0x91,0x40,0x7F with CHANNEL=0 and OMNI=0 SHALL produce no pulse; with OMNI=1 they SHALL produce o_note_on.
REQ-040 Bytes 0xB0,0xF8,0x07,0xFE,0x64 SHALL produce o_cc_valid with o_cc_num=0x07, o_cc_value=0x64 (real-time bytes transparent).
REQ-041 Bytes 0xE0,0x00,0x40 SHALL produce o_bend_valid with o_bend=0x2000; 0xE0,0x7F,0x7F SHALL produce o_bend=0x3FFF.
REQ-042 Bytes 0xF0,0x3C,0x64,0xF7,0x3C,0x64 SHALL produce no output; bytes 0x90,0x3C with reset asserted, then 0x64, SHALL produce no output.
